// File: rtl/fm_discriminator.sv
// Cross-product FM discriminator: y = Q[n]*I[n-1] - I[n]*Q[n-1], scaled by >>>SHIFT and saturated to WIDTH bits.
// Latency 3 cycles from accepting edge to valid_o; one sample per cycle, no backpressure; start_i low flushes and un-primes.
module fm_discriminator #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               valid_i,
    input  logic [2*WIDTH-1:0] data_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               sat_o
);
    localparam int PW = 2 * WIDTH;
    localparam int DW = PW + 1;
    localparam logic signed [DW-1:0] S_MAX = {{(DW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {{(DW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] in_i, in_q;
    logic                    accept;
    logic signed [DW-1:0]    scaled;

    logic signed [WIDTH-1:0] hist_i_q, hist_i_d, hist_q_q, hist_q_d;
    logic                    primed_q, primed_d;
    logic                    s1_vld_q, s1_vld_d;
    logic signed [WIDTH-1:0] s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic signed [WIDTH-1:0] s1_pi_q, s1_pi_d, s1_pq_q, s1_pq_d;
    logic                    s2_vld_q, s2_vld_d;
    logic signed [PW-1:0]    s2_pa_q, s2_pa_d, s2_pb_q, s2_pb_d;
    logic                    s3_vld_q, s3_vld_d;
    logic signed [DW-1:0]    s3_y_q, s3_y_d;
    logic                    valid_q, valid_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    sat_q, sat_d;

    assign in_i   = data_i[PW-1:WIDTH];
    assign in_q   = data_i[WIDTH-1:0];
    assign accept = start_i && valid_i;

    always_comb begin
        hist_i_d = hist_i_q;
        hist_q_d = hist_q_q;
        primed_d = primed_q;
        s1_i_d   = s1_i_q;
        s1_q_d   = s1_q_q;
        s1_pi_d  = s1_pi_q;
        s1_pq_d  = s1_pq_q;
        s1_vld_d = 1'b0;
        data_d   = data_q;
        sat_d    = sat_q;

        // S1: pair the new sample with history; only a primed block emits
        if (accept) begin
            s1_i_d   = in_i;
            s1_q_d   = in_q;
            s1_pi_d  = hist_i_q;
            s1_pq_d  = hist_q_q;
            hist_i_d = in_i;
            hist_q_d = in_q;
            s1_vld_d = primed_q;
            primed_d = 1'b1;
        end
        if (!start_i) begin
            primed_d = 1'b0;
        end

        s2_vld_d = s1_vld_q && start_i;
        s2_pa_d  = PW'(s1_q_q) * PW'(s1_pi_q);
        s2_pb_d  = PW'(s1_i_q) * PW'(s1_pq_q);

        // One extra bit keeps the difference of two full-range products exact
        s3_vld_d = s2_vld_q && start_i;
        s3_y_d   = DW'(s2_pa_q) - DW'(s2_pb_q);

        scaled  = s3_y_q >>> SHIFT;
        valid_d = s3_vld_q && start_i;
        if (valid_d) begin
            if (scaled > S_MAX) begin
                data_d = S_MAX[WIDTH-1:0];
                sat_d  = 1'b1;
            end else if (scaled < S_MIN) begin
                data_d = S_MIN[WIDTH-1:0];
                sat_d  = 1'b1;
            end else begin
                data_d = scaled[WIDTH-1:0];
                sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_i_q <= '0;
            hist_q_q <= '0;
            primed_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_i_q   <= '0;
            s1_q_q   <= '0;
            s1_pi_q  <= '0;
            s1_pq_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_pa_q  <= '0;
            s2_pb_q  <= '0;
            s3_vld_q <= 1'b0;
            s3_y_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            hist_i_q <= hist_i_d;
            hist_q_q <= hist_q_d;
            primed_q <= primed_d;
            s1_vld_q <= s1_vld_d;
            s1_i_q   <= s1_i_d;
            s1_q_q   <= s1_q_d;
            s1_pi_q  <= s1_pi_d;
            s1_pq_q  <= s1_pq_d;
            s2_vld_q <= s2_vld_d;
            s2_pa_q  <= s2_pa_d;
            s2_pb_q  <= s2_pb_d;
            s3_vld_q <= s3_vld_d;
            s3_y_q   <= s3_y_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sat_q    <= sat_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sat_o   = sat_q;
endmodule

// File: tb/tb_fm_discriminator.sv
// Bench for fm_discriminator: directed test-plan sequences plus random traffic against an arithmetic reference model.
module tb_fm_discriminator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        valid_o;
    logic [15:0] data_o;
    logic        sat_o;

    fm_discriminator #(.WIDTH(16), .SHIFT(15)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
        .data_i(data_i), .valid_o(valid_o), .data_o(data_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int d;
        bit s;
    } exp_t;

    exp_t pend[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   prev_i = 0, prev_q = 0;
    bit   primed = 0;
    int   last_d = 0;
    bit   last_s = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void ref_out(input int i0, input int q0, input int i1, input int q1,
                                    output int d, output bit s);
        longint y, sc;
        y  = longint'(q1) * longint'(i0) - longint'(i1) * longint'(q0);
        sc = y >>> 15;
        if (sc > 32767) begin
            d = 32767; s = 1;
        end else if (sc < -32768) begin
            d = -32768; s = 1;
        end else begin
            d = int'(sc); s = 0;
        end
    endfunction

    task automatic check_out();
        if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("valid", longint'(valid_o), 1);
            chk("data", longint'($signed(data_o)), pend[0].d);
            chk("sat", longint'(sat_o), pend[0].s);
            last_d = pend[0].d;
            last_s = pend[0].s;
            void'(pend.pop_front());
        end else begin
            chk("idle_valid", longint'(valid_o), 0);
            chk("hold_data", longint'($signed(data_o)), last_d);
            chk("hold_sat", longint'(sat_o), last_s);
        end
        if (valid_o) pulses++;
    endtask

    task automatic step(input bit st, input bit vl, input int i, input int q);
        exp_t e;
        start_i = st;
        valid_i = vl;
        data_i  = {i[15:0], q[15:0]};
        @(posedge clk);
        cyc++;
        if (!st) begin
            pend.delete();
            primed = 0;
        end else if (vl) begin
            if (primed) begin
                e.due = cyc + 3;
                ref_out(prev_i, prev_q, i, q, e.d, e.s);
                pend.push_back(e);
            end
            prev_i = i;
            prev_q = q;
            primed = 1;
        end
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0);
    endtask

    function automatic int rnd16();
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        int p0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", longint'(valid_o), 0);
        chk("rst_data", longint'(data_o), 0);
        chk("rst_sat", longint'(sat_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Counter-clockwise quarter turn
        step(1, 1, 16384, 0);
        step(1, 1, 0, 16384);
        idle(3);
        chk("ccw_data", longint'($signed(data_o)), 8192);
        chk("ccw_sat", longint'(sat_o), 0);
        step(0, 0, 0, 0);

        // Clockwise quarter turn
        step(1, 1, 0, 16384);
        step(1, 1, 16384, 0);
        idle(3);
        chk("cw_data", longint'($signed(data_o)), -8192);
        chk("cw_sat", longint'(sat_o), 0);
        step(0, 0, 0, 0);

        // Positive saturation
        step(1, 1, -32768, 32767);
        step(1, 1, -32768, -32768);
        idle(3);
        chk("satp_data", longint'($signed(data_o)), 32767);
        chk("satp_sat", longint'(sat_o), 1);
        step(0, 0, 0, 0);

        // Back-to-back: six samples give five consecutive pulses
        p0 = pulses;
        for (int k = 0; k < 6; k++) step(1, 1, rnd16(), rnd16());
        idle(4);
        chk("b2b_pulses", pulses - p0, 5);

        // Async reset with two samples in flight
        step(1, 1, 12000, -3000);
        step(1, 1, -20000, 9000);
        step(1, 1, 7000, 25000);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", longint'(valid_o), 0);
        chk("arst_data", longint'(data_o), 0);
        chk("arst_sat", longint'(sat_o), 0);
        pend.delete();
        primed = 0; prev_i = 0; prev_q = 0; last_d = 0; last_s = 0;
        @(negedge clk) rst = 1'b0;
        p0 = pulses;
        idle(5);
        step(1, 1, 30000, -30000);
        idle(4);
        chk("arst_no_pulse", pulses - p0, 0);

        // Flush between samples 3 and 4, strobes while disabled, re-enable with valid
        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, rnd16(), rnd16());
        p0 = pulses;
        step(0, 1, rnd16(), rnd16());
        step(0, 1, rnd16(), rnd16());
        step(0, 0, 0, 0);
        chk("flush_pulses", pulses - p0, 0);
        step(1, 1, -16384, 16384);
        step(1, 1, 16384, 16384);
        idle(4);
        chk("reprime_data", longint'($signed(data_o)), -16384);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, rnd16(), rnd16());
        end
        idle(4);
        chk("drain_empty", longint'(pend.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fm_discriminator.md
Name: fm_discriminator

Overview:
- Downstream consumer of the merge stage in the FM demodulator chain.
- Takes each merged 2*WIDTH-bit complex baseband sample {I,Q}, qualified by the merge stage's finished strobe.
- Computes the cross-product FM discriminator against the previous sample, then scales and saturates the result to WIDTH bits.
- The output stream feeds the split stage or an audio path, one demodulated sample per input sample after priming.

Parameters:
- WIDTH, 16, bit width of each of I and Q and of data_o (signed two's complement).
- SHIFT, 15, arithmetic right shift applied to the full-precision discriminator before saturation.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  stream enable, shared with the merge/split stages. Low flushes the pipeline and un-primes the block.
- valid_i  input  1  one-cycle sample strobe (connects to merge_finished_o).
- data_i  input  2*WIDTH  merged sample. [2*WIDTH-1:WIDTH] = I, [WIDTH-1:0] = Q, both signed.
- valid_o  output  1  one-cycle strobe qualifying data_o.
- data_o  output  WIDTH  signed demodulated sample.
- sat_o  output  1  high with valid_o when data_o was clipped.

Behaviour:
- Reset (async, rst=1): valid_o=0, data_o=0, sat_o=0. History I/Q=0, primed=0, all pipeline valid bits=0. Takes effect immediately, including mid-pipeline; in-flight samples are discarded.
- Discriminator: y = Q[n]*I[n-1] - I[n]*Q[n-1].
  - Products are signed, 2*WIDTH bits each.
  - Difference is 2*WIDTH+1 bits signed; no intermediate overflow is permitted.
  - Counter-clockwise rotation gives positive y.
- Scaling: s = y >>> SHIFT (arithmetic, floor; no rounding).
  - If s > 2^(WIDTH-1)-1: data_o = 2^(WIDTH-1)-1, sat_o=1.
  - If s < -2^(WIDTH-1): data_o = -2^(WIDTH-1), sat_o=1.
  - Otherwise data_o = s[WIDTH-1:0], sat_o=0.
- Pipeline: fixed 3-cycle latency; accepts valid_i every cycle with no backpressure.
  - S1 (edge where valid_i&&start_i): capture current I/Q and previous history; update history to current; emit stage valid only if primed=1; set primed=1.
  - S2: two products registered.
  - S3: difference, shift and saturate registered into data_o/sat_o; valid_o asserted.
  - valid_o is high exactly 3 edges after the accepting edge, for one cycle.
- Priming: the first accepted sample after reset or after start_i rises only loads history and produces no output.
- start_i=0:
  - valid_i is ignored; primed cleared; all pipeline valid bits cleared on the next edge.
  - valid_o=0 from that edge on; data_o/sat_o hold their last values.
- valid_i high while start_i=0: ignored, history unchanged.
- Simultaneous start_i rising with valid_i on the same edge: the sample is accepted as the priming sample.
- Between strobes: data_o and sat_o hold their values; sat_o is meaningful only while valid_o=1.

Test Plan:
1. Assert rst mid-stream with two samples in flight → valid_o, data_o and sat_o are 0 immediately (before the next edge). No valid_o pulse follows. The next accepted sample only primes.
2. start_i=1, then samples (I=16384,Q=0) and (I=0,Q=16384) on consecutive edges → no output for the first sample. For the second, valid_o fires 3 edges after acceptance with data_o=8192, sat_o=0.
3. Reverse rotation: (0,16384) then (16384,0) → data_o=-8192, sat_o=0.
4. Saturation: (-32768,32767) then (-32768,-32768) → y=2147450880, s=65535, data_o=32767, sat_o=1.
5. Back-to-back: 6 samples on 6 consecutive edges → exactly 5 valid_o pulses on consecutive cycles, each 3 edges after its input, with values matching a software model.
6. Drop start_i between sample 3 and sample 4 of a stream, then re-raise it:
   - Outputs already in flight are cancelled.
   - valid_i pulses while start_i=0 produce nothing.
   - The first sample after re-enable primes only; the second yields output computed against it, not against pre-flush history.
